// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM encoding, forwarding codes and arbiter defaults
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, IF_XFER, D_XFER} arb_state_e;
  typedef enum logic [1:0] {FWD_NONE, FWD_EX_MEM, FWD_MEM_WB} fwd_e;
  localparam int STARVE_MAX_DEF = 4;
  function automatic int cnt_w(input int max);
    return max < 1 ? 1 : $clog2(max + 1);
  endfunction
endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: saturating count of data grants taken while fetch waits
module mem_arb_starve_ctr import mem_port_arbiter_pkg::*; #(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int W = cnt_w(STARVE_MAX);
  localparam logic [W-1:0] MAX = W'(STARVE_MAX);
  logic [W-1:0] cnt_q, cnt_d;
  // clear wins over increment; increment stops at the saturation value
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign sat = cnt_q == MAX;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access
module mem_port_arbiter import mem_port_arbiter_pkg::*; #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  input  logic                flush,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                if_stall,
  output logic                d_stall
);
  arb_state_e          state_q;
  logic                drop_q, if_ack_q, d_ack_q, mem_req_q, mem_we_q, sat;
  logic [DATA_W/8-1:0] mem_be_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q, if_rdata_q, d_rdata_q;
  logic                idle, if_elig, d_elig, grant_if, grant_d;
  // a requester acked this cycle is ineligible; fetch also loses to a flush
  always_comb begin
    idle     = state_q == IDLE;
    if_elig  = if_req & ~if_ack_q & ~flush;
    d_elig   = d_req & ~d_ack_q;
    grant_if = idle & if_elig & (~d_elig | sat);
    grant_d  = idle & d_elig & ~grant_if;
  end
  mem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk(clk),
    .rst(rst),
    .inc(grant_d & if_req),
    .clr(grant_if | ~if_req),
    .sat(sat)
  );
  // grant, hold the memory request until ready, then capture data and pulse ack
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      drop_q      <= 1'b0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_if) begin
            state_q     <= IF_XFER;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '1;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
          end else if (grant_d) begin
            state_q     <= D_XFER;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_be_q    <= d_be;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
          end
        end
        IF_XFER: begin
          if (mem_ready) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            drop_q    <= 1'b0;
            if (!drop_q && !flush) begin
              if_rdata_q <= mem_rdata;
              if_ack_q   <= 1'b1;
            end
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        D_XFER: begin
          if (mem_ready) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            d_ack_q   <= 1'b1;
            if (!mem_we_q) d_rdata_q <= mem_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ack    = if_ack_q & ~flush;
  assign d_ack     = d_ack_q;
  assign if_stall  = if_req & ~if_ack;
  assign d_stall   = d_req & ~d_ack;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the fetch/data memory port arbiter
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, flush = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, mem_req, mem_we, if_stall, d_stall;
  logic [3:0]  mem_be;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .if_stall(if_stall), .d_stall(d_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        dat;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mx_t;

  mx_t         mq[$];
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  mx_t         me;
  int          n_chk = 0, n_fail = 0;
  int          lat = 0, wcnt = 0;
  logic [31:0] last_if = '0, last_d = '0;

  function automatic logic [31:0] mdat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pushf(input logic [31:0] a);
    mq.push_back('{dat: 1'b0, we: 1'b0, be: 4'h0, addr: a, wdata: 32'h0});
    iq.push_back(mdat(a));
    last_if = mdat(a);
  endtask

  task automatic pushd(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    mq.push_back('{dat: 1'b1, we: we, be: be, addr: a, wdata: wd});
    if (!we) last_d = mdat(a);
    dq.push_back(last_d);
  endtask

  // runs until both requests are retired; d_req drops after d_n acks, flush optionally mirrors d_ack
  task automatic run(input int d_n, input bit fl, input int maxc);
    int  dseen;
    logic ia, da;
    dseen = 0;
    for (int i = 0; i < maxc; i++) begin
      tick;
      ia = if_ack;
      da = d_ack;
      flush = fl & da;
      if (ia) if_req = 1'b0;
      if (da) dseen++;
      if (da && dseen >= d_n) d_req = 1'b0;
      if (!if_req && !d_req) break;
    end
    n_chk++;
    if (if_req || d_req) begin
      n_fail++;
      $display("FAIL run_timeout: requests still pending if_req=%0b d_req=%0b", if_req, d_req);
    end
    if_req = 1'b0;
    d_req = 1'b0;
    flush = 1'b0;
  endtask

  // memory model: ready after lat wait cycles, checks each completed transfer in order
  always @(negedge clk) begin
    mem_rdata = mdat(mem_addr);
    if (mem_req) begin
      mem_ready = wcnt >= lat;
      wcnt = mem_ready ? 0 : wcnt + 1;
      if (mem_ready) begin
        if (mq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL mem_xfer: unexpected transfer addr %h", mem_addr);
        end else begin
          me = mq.pop_front();
          chk("mem_addr", mem_addr, me.addr);
          chk("mem_we", {31'b0, mem_we}, {31'b0, me.we});
          if (me.dat) begin
            chk("mem_be", {28'b0, mem_be}, {28'b0, me.be});
            chk("mem_wdata", mem_wdata, me.wdata);
          end
        end
      end
    end else begin
      mem_ready = 1'b0;
      wcnt = 0;
    end
  end

  // ack monitor: every ack must match the next expected read value
  always @(negedge clk) begin
    if (if_ack === 1'b1) begin
      if (iq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL if_ack: unexpected pulse rdata %h", if_rdata);
      end else chk("if_rdata", if_rdata, iq.pop_front());
    end
    if (d_ack === 1'b1) begin
      if (dq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL d_ack: unexpected pulse rdata %h", d_rdata);
      end else chk("d_rdata", d_rdata, dq.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if_req = 1'b1;
    d_req = 1'b1;
    flush = 1'b1;
    repeat (3) tick;
    @(negedge clk);
    chk("rst mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst mem_be", {28'b0, mem_be}, 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst if_ack", {31'b0, if_ack}, 32'h0);
    chk("rst d_ack", {31'b0, d_ack}, 32'h0);
    chk("rst if_rdata", if_rdata, 32'h0);
    chk("rst d_rdata", d_rdata, 32'h0);
    tick;
    rst = 1'b0;
    if_req = 1'b0;
    d_req = 1'b0;
    flush = 1'b0;
    tick;
    // single fetch, minimum latency
    if_addr = 32'h100;
    if_req = 1'b1;
    pushf(32'h100);
    @(negedge clk);
    chk("c0 mem_req", {31'b0, mem_req}, 32'h0);
    chk("c0 if_stall", {31'b0, if_stall}, 32'h1);
    tick;
    @(negedge clk);
    chk("c1 mem_req", {31'b0, mem_req}, 32'h1);
    chk("c1 mem_addr", mem_addr, 32'h100);
    chk("c1 mem_we", {31'b0, mem_we}, 32'h0);
    tick;
    @(negedge clk);
    chk("c2 if_ack", {31'b0, if_ack}, 32'h1);
    chk("c2 if_stall", {31'b0, if_stall}, 32'h0);
    tick;
    if_req = 1'b0;
    tick;
    // simultaneous requests: data first, then fetch
    d_we = 1'b0;
    d_be = 4'hf;
    d_wdata = 32'h0;
    d_addr = 32'h200;
    if_addr = 32'h104;
    if_req = 1'b1;
    d_req = 1'b1;
    pushd(1'b0, 4'hf, 32'h200, 32'h0);
    pushf(32'h104);
    run(1, 1'b0, 40);
    tick;
    // six held loads with fetch waiting: fourth data grant saturates, fifth grant is fetch
    d_addr = 32'h300;
    if_addr = 32'h400;
    if_req = 1'b1;
    d_req = 1'b1;
    for (int i = 0; i < 4; i++) pushd(1'b0, 4'hf, 32'h300, 32'h0);
    pushf(32'h400);
    for (int i = 0; i < 2; i++) pushd(1'b0, 4'hf, 32'h300, 32'h0);
    run(6, 1'b1, 100);
    tick;
    // fetch with three wait cycles, flushed in the second: no ack, rdata held
    lat = 3;
    if_addr = 32'h500;
    if_req = 1'b1;
    mq.push_back('{dat: 1'b0, we: 1'b0, be: 4'h0, addr: 32'h500, wdata: 32'h0});
    tick;
    @(negedge clk);
    chk("fl w1 mem_req", {31'b0, mem_req}, 32'h1);
    tick;
    flush = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    chk("fl w2 mem_req", {31'b0, mem_req}, 32'h1);
    tick;
    flush = 1'b0;
    @(negedge clk);
    chk("fl w3 mem_req", {31'b0, mem_req}, 32'h1);
    chk("fl w3 mem_addr", mem_addr, 32'h500);
    tick;
    @(negedge clk);
    chk("fl rdy mem_req", {31'b0, mem_req}, 32'h1);
    tick;
    @(negedge clk);
    chk("fl if_ack", {31'b0, if_ack}, 32'h0);
    chk("fl mem_req idle", {31'b0, mem_req}, 32'h0);
    chk("fl if_rdata held", if_rdata, last_if);
    tick;
    @(negedge clk);
    chk("fl if_rdata still", if_rdata, last_if);
    lat = 0;
    tick;
    // flush landing on the ack cycle suppresses the pulse
    if_addr = 32'h800;
    if_req = 1'b1;
    mq.push_back('{dat: 1'b0, we: 1'b0, be: 4'h0, addr: 32'h800, wdata: 32'h0});
    tick;
    tick;
    flush = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    chk("ack-cycle flush if_ack", {31'b0, if_ack}, 32'h0);
    tick;
    flush = 1'b0;
    tick;
    // partial store: byte enables forwarded, d_rdata untouched
    d_we = 1'b1;
    d_be = 4'b0011;
    d_addr = 32'h600;
    d_wdata = 32'hDEADBEEF;
    d_req = 1'b1;
    pushd(1'b1, 4'b0011, 32'h600, 32'hDEADBEEF);
    tick;
    @(negedge clk);
    chk("st mem_we", {31'b0, mem_we}, 32'h1);
    chk("st mem_be", {28'b0, mem_be}, 32'h3);
    tick;
    d_req = 1'b0;
    d_we = 1'b0;
    d_be = 4'hf;
    @(negedge clk);
    chk("st d_ack", {31'b0, d_ack}, 32'h1);
    chk("st d_rdata", d_rdata, last_d);
    tick;
    // reset during a stalled data transfer abandons it
    lat = 100;
    d_addr = 32'h700;
    if_addr = 32'h900;
    d_req = 1'b1;
    if_req = 1'b1;
    tick;
    @(negedge clk);
    chk("pre-rst mem_req", {31'b0, mem_req}, 32'h1);
    chk("pre-rst starve_cnt", 32'(dut.u_starve.cnt_q), 32'h1);
    tick;
    rst = 1'b1;
    d_req = 1'b0;
    tick;
    rst = 1'b0;
    if_req = 1'b0;
    @(negedge clk);
    chk("rst xfer mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst xfer d_ack", {31'b0, d_ack}, 32'h0);
    chk("rst xfer starve_cnt", 32'(dut.u_starve.cnt_q), 32'h0);
    lat = 0;
    repeat (5) tick;
    chk("mem queue drained", mq.size(), 32'h0);
    chk("if queue drained", iq.size(), 32'h0);
    chk("d queue drained", dq.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
